// File: rtl/hyper_pkg.sv
// Shared sizes and the dispatch FSM state type for the LSAB-to-DRAM dispatch slice.
package hyper_pkg;

   localparam int SECTIONS    = 4;
   localparam int DRAM_ADDR_W = 12;
   localparam int MV_COUNT_W  = 6;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SELECT     = 3'd1,
      ST_ISSUE      = 3'd2,
      ST_WAIT_START = 3'd3,
      ST_WAIT_DONE  = 3'd4,
      ST_UPDATE     = 3'd5
   } dispatch_state_e;

endpackage

// File: rtl/hyper_rr_pick4.sv
// Combinational 4-way round-robin select: first set request at or after the pointer.
module hyper_rr_pick4 (
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [1:0] idx_o,
   output logic       valid_o
);

   always_comb begin
      idx_o   = 2'd0;
      valid_o = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // 2-bit sum wraps 3 -> 0 by construction
         if (!valid_o && req_i[ptr_i + 2'(i)]) begin
            idx_o   = ptr_i + 2'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hyper_todram_dispatch.sv
// Holds one descriptor per LSAB section and feeds bounded block requests to the mover.
// Handshake: MV_ISSUE is a one-cycle strobe with MV_* held until WORKING has risen and fallen.
module hyper_todram_dispatch
   import hyper_pkg::*;
#(
   parameter int MAX_BLOCK = 32,
   parameter int LEN_W     = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   DESC_WE,
   input  logic [1:0]             DESC_SECTION,
   input  logic [DRAM_ADDR_W-1:0] DESC_ADDR,
   input  logic [LEN_W-1:0]       DESC_LEN,
   output logic                   DESC_ERR,
   input  logic [SECTIONS-1:0]    LSAB_NONEMPTY,
   output logic [DRAM_ADDR_W-1:0] MV_START_ADDRESS,
   output logic [MV_COUNT_W-1:0]  MV_COUNT_REQ,
   output logic [1:0]             MV_SECTION,
   output logic                   MV_ISSUE,
   input  logic [MV_COUNT_W-1:0]  MV_COUNT_SENT,
   input  logic                   MV_WORKING,
   output logic [SECTIONS-1:0]    PENDING,
   output logic [SECTIONS-1:0]    DONE,
   output logic                   BUSY
);

   localparam logic [LEN_W-1:0] BLOCK_MAX = LEN_W'(MAX_BLOCK);

   dispatch_state_e        state_q, state_d;
   logic [DRAM_ADDR_W-1:0] addr_q [SECTIONS];
   logic [DRAM_ADDR_W-1:0] addr_d [SECTIONS];
   logic [LEN_W-1:0]       len_q  [SECTIONS];
   logic [LEN_W-1:0]       len_d  [SECTIONS];
   logic [1:0]             ptr_q, ptr_d;
   logic [1:0]             cur_q, cur_d;
   logic [DRAM_ADDR_W-1:0] mv_addr_q, mv_addr_d;
   logic [MV_COUNT_W-1:0]  mv_count_q, mv_count_d;
   logic [1:0]             mv_sec_q, mv_sec_d;
   logic [SECTIONS-1:0]    done_q, done_d;
   logic                   err_q, err_d;

   logic [SECTIONS-1:0]    eligible;
   logic [1:0]             pick_idx;
   logic                   pick_valid;
   logic                   in_flight;
   logic [LEN_W-1:0]       sent_ext;
   logic [LEN_W-1:0]       len_cur;
   logic [LEN_W-1:0]       len_after;
   logic [LEN_W-1:0]       len_pick;

   always_comb begin
      PENDING = '0;
      for (int n = 0; n < SECTIONS; n++) PENDING[n] = (len_q[n] != '0);
   end

   assign eligible = PENDING & LSAB_NONEMPTY;

   hyper_rr_pick4 u_pick (
      .req_i   (eligible),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT_START) ||
                      (state_q == ST_WAIT_DONE) || (state_q == ST_UPDATE);
   assign sent_ext  = LEN_W'(MV_COUNT_SENT);
   assign len_cur   = len_q[cur_q];
   // A mover reporting more than was left is clamped rather than wrapping
   assign len_after = (sent_ext > len_cur) ? '0 : len_cur - sent_ext;
   assign len_pick  = len_q[pick_idx];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cur_d      = cur_q;
      mv_addr_d  = mv_addr_q;
      mv_count_d = mv_count_q;
      mv_sec_d   = mv_sec_q;
      done_d     = '0;
      err_d      = 1'b0;
      addr_d     = addr_q;
      len_d      = len_q;

      case (state_q)
         ST_IDLE: if (|eligible) state_d = ST_SELECT;
         ST_SELECT: begin
            if (pick_valid) begin
               cur_d      = pick_idx;
               mv_addr_d  = addr_q[pick_idx];
               mv_count_d = (len_pick > BLOCK_MAX) ? MV_COUNT_W'(BLOCK_MAX) : MV_COUNT_W'(len_pick);
               mv_sec_d   = pick_idx;
               state_d    = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE:      state_d = ST_WAIT_START;
         ST_WAIT_START: if (MV_WORKING) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE:  if (!MV_WORKING) state_d = ST_UPDATE;
         ST_UPDATE: begin
            addr_d[cur_q] = addr_q[cur_q] + DRAM_ADDR_W'(MV_COUNT_SENT);
            len_d[cur_q]  = len_after;
            // Pointer moves even on zero progress so a starved section cannot hog the mover
            ptr_d         = cur_q + 2'd1;
            if (len_after == '0) done_d[cur_q] = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // UPDATE only touches cur, and writes to cur are rejected while in flight
      if (DESC_WE) begin
         if (in_flight && (DESC_SECTION == cur_q)) begin
            err_d = 1'b1;
         end else if (DESC_LEN == '0) begin
            addr_d[DESC_SECTION] = '0;
            len_d[DESC_SECTION]  = '0;
         end else begin
            addr_d[DESC_SECTION] = DESC_ADDR;
            len_d[DESC_SECTION]  = DESC_LEN;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 2'd0;
         cur_q      <= 2'd0;
         mv_addr_q  <= '0;
         mv_count_q <= '0;
         mv_sec_q   <= 2'd0;
         done_q     <= '0;
         err_q      <= 1'b0;
         for (int n = 0; n < SECTIONS; n++) begin
            addr_q[n] <= '0;
            len_q[n]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_q      <= cur_d;
         mv_addr_q  <= mv_addr_d;
         mv_count_q <= mv_count_d;
         mv_sec_q   <= mv_sec_d;
         done_q     <= done_d;
         err_q      <= err_d;
         for (int n = 0; n < SECTIONS; n++) begin
            addr_q[n] <= addr_d[n];
            len_q[n]  <= len_d[n];
         end
      end
   end

   assign MV_START_ADDRESS = mv_addr_q;
   assign MV_COUNT_REQ     = mv_count_q;
   assign MV_SECTION       = mv_sec_q;
   assign MV_ISSUE         = (state_q == ST_ISSUE);
   assign DONE             = done_q;
   assign DESC_ERR         = err_q;
   assign BUSY             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hyper_todram_dispatch.sv
// Randomized bench for hyper_todram_dispatch: a mover model answers each block and a
// descriptor-level reference model predicts every issue, DONE pulse and PENDING mask.
module tb_hyper_todram_dispatch;

   localparam int MAX_BLOCK = 32;
   localparam int LEN_W     = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              desc_we;
   logic [1:0]        desc_section;
   logic [11:0]       desc_addr;
   logic [LEN_W-1:0]  desc_len;
   logic              desc_err;
   logic [3:0]        lsab;
   logic [11:0]       mv_start_address;
   logic [5:0]        mv_count_req;
   logic [1:0]        mv_section;
   logic              mv_issue;
   logic [5:0]        mv_count_sent;
   logic              mv_working;
   logic [3:0]        pending;
   logic [3:0]        done;
   logic              busy;

   always #5 clk = ~clk;

   hyper_todram_dispatch #(.MAX_BLOCK(MAX_BLOCK), .LEN_W(LEN_W)) dut (
      .CLK              (clk),
      .RST              (rst),
      .DESC_WE          (desc_we),
      .DESC_SECTION     (desc_section),
      .DESC_ADDR        (desc_addr),
      .DESC_LEN         (desc_len),
      .DESC_ERR         (desc_err),
      .LSAB_NONEMPTY    (lsab),
      .MV_START_ADDRESS (mv_start_address),
      .MV_COUNT_REQ     (mv_count_req),
      .MV_SECTION       (mv_section),
      .MV_ISSUE         (mv_issue),
      .MV_COUNT_SENT    (mv_count_sent),
      .MV_WORKING       (mv_working),
      .PENDING          (pending),
      .DONE             (done),
      .BUSY             (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: descriptor contents and round-robin pointer
   logic [11:0] addr_m [4];
   int          len_m  [4];
   int          ptr_m;
   logic [19:0] exp_q [$];

   function automatic logic [3:0] pend_m();
      logic [3:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) p[i] = (len_m[i] > 0);
      return p;
   endfunction

   function automatic int pick_m();
      for (int i = 0; i < 4; i++) begin
         int s;
         s = (ptr_m + i) % 4;
         if (len_m[s] > 0 && lsab[s]) return s;
      end
      return -1;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         addr_m[i] = '0;
         len_m[i]  = 0;
      end
      ptr_m = 0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_issue"},   mv_issue, 0);
      chk({tag, "_addr"},    mv_start_address, 0);
      chk({tag, "_count"},   mv_count_req, 0);
      chk({tag, "_section"}, mv_section, 0);
      chk({tag, "_pending"}, pending, 0);
      chk({tag, "_done"},    done, 0);
      chk({tag, "_err"},     desc_err, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mv_working = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   task automatic load_desc(input int sec, input int addr, input int len);
      desc_we      = 1'b1;
      desc_section = sec[1:0];
      desc_addr    = addr[11:0];
      desc_len     = len[LEN_W-1:0];
      @(negedge clk);
      desc_we = 1'b0;
      chk("load_err", desc_err, 0);
      addr_m[sec] = (len == 0) ? 12'h000 : addr[11:0];
      len_m[sec]  = len;
      chk("load_pending", pending, pend_m());
      chk("load_no_done", done, 0);
   endtask

   // policy: 0 full, 1 zero progress, 2 partial, 3 over-report
   task automatic serve_block(input int policy, input bit inject_err, input bit reset_mid);
      int s, cnt, sent, waited, hold;
      logic [19:0] exp_w;
      logic [3:0] exp_done;
      s = pick_m();
      if (s < 0) return;
      cnt = (len_m[s] > MAX_BLOCK) ? MAX_BLOCK : len_m[s];
      exp_w = {s[1:0], addr_m[s], cnt[5:0]};
      exp_q.push_back(exp_w);
      waited = 0;
      while (mv_issue !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (mv_issue !== 1'b1) begin
         chk("issue_timeout", 0, 1);
         void'(exp_q.pop_front());
         return;
      end
      chk("issue", {mv_section, mv_start_address, mv_count_req}, exp_q.pop_front());
      chk("busy_issue", busy, 1);
      @(negedge clk);
      chk("issue_one_cycle", mv_issue, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mv_working = 1'b1;
      @(negedge clk);
      if (inject_err) begin
         desc_we      = 1'b1;
         desc_section = s[1:0];
         desc_addr    = 12'hABC;
         desc_len     = 16'd777;
         @(negedge clk);
         desc_we = 1'b0;
         chk("inflight_err", desc_err, 1);
         chk("inflight_pending", pending, pend_m());
      end
      if (reset_mid) begin
         rst = 1'b1;
         mv_working = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         clear_model();
         check_reset_state("midrst");
         return;
      end
      hold = $urandom_range(1, 4);
      repeat (hold) begin
         @(negedge clk);
         chk("mv_hold", {mv_section, mv_start_address, mv_count_req}, exp_w);
         chk("issue_low", mv_issue, 0);
      end
      case (policy)
         0:       sent = cnt;
         1:       sent = 0;
         2:       sent = $urandom_range(0, cnt);
         default: sent = cnt + $urandom_range(1, 3);
      endcase
      mv_working    = 1'b0;
      mv_count_sent = sent[5:0];
      @(negedge clk);
      chk("done_early", done, 0);
      addr_m[s] = addr_m[s] + sent[11:0];
      len_m[s]  = (sent > len_m[s]) ? 0 : len_m[s] - sent;
      ptr_m     = (s + 1) % 4;
      exp_done  = (len_m[s] == 0) ? (4'b0001 << s) : 4'b0000;
      @(negedge clk);
      chk("done", done, exp_done);
      chk("pending", pending, pend_m());
      chk("busy_idle", busy, 0);
   endtask

   task automatic check_quiet(input string tag);
      int seen;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (mv_issue === 1'b1) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      rst           = 1'b1;
      desc_we       = 1'b0;
      desc_section  = '0;
      desc_addr     = '0;
      desc_len      = '0;
      lsab          = '0;
      mv_count_sent = '0;
      mv_working    = 1'b0;
      clear_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // single short block
      load_desc(1, 12'h100, 10);
      lsab = 4'b0010;
      serve_block(0, 0, 0);
      chk("s1_pending_clear", pending, 0);

      // long descriptor split into 32, 32, 6
      lsab = 4'b0000;
      load_desc(0, 12'h200, 70);
      lsab = 4'b0001;
      repeat (3) serve_block(0, 0, 0);

      // two eligible sections alternate; section 1 pending but LSAB empty
      lsab = 4'b0000;
      load_desc(0, 12'h300, 64);
      load_desc(2, 12'h400, 64);
      load_desc(1, 12'h500, 5);
      lsab = 4'b0101;
      repeat (4) serve_block(0, 0, 0);
      check_quiet("starved_never_issued");
      chk("starved_pending", pending, 4'b0010);
      lsab = 4'b0000;
      load_desc(1, 12'h000, 0);

      // zero progress leaves descriptor intact and moves the pointer
      load_desc(3, 12'h050, 5);
      load_desc(0, 12'h060, 3);
      lsab = 4'b1001;
      serve_block(1, 0, 0);
      serve_block(0, 0, 0);
      serve_block(0, 0, 0);

      // address wrap at 4096
      lsab = 4'b0000;
      load_desc(2, 12'hFF0, 40);
      lsab = 4'b0100;
      repeat (2) serve_block(0, 0, 0);

      // load to the in-flight section is rejected
      lsab = 4'b0000;
      load_desc(1, 12'h123, 40);
      lsab = 4'b0010;
      serve_block(0, 1, 0);
      serve_block(0, 0, 0);

      // over-reported count saturates the remaining length
      lsab = 4'b0000;
      load_desc(3, 12'h700, 7);
      lsab = 4'b1000;
      serve_block(3, 0, 0);

      // reset while waiting for the mover to finish
      lsab = 4'b0000;
      load_desc(1, 12'h222, 20);
      lsab = 4'b0010;
      serve_block(0, 0, 1);
      check_quiet("quiet_after_reset");

      // randomized rounds
      for (int round = 0; round < 6; round++) begin
         int iter;
         lsab = 4'b0000;
         @(negedge clk);
         for (int sec = 0; sec < 4; sec++)
            load_desc(sec, $urandom_range(0, 4095), $urandom_range(0, 150));
         lsab = 4'($urandom_range(1, 15));
         iter = 0;
         while (pick_m() >= 0 && iter < 80) begin
            serve_block((iter < 40) ? $urandom_range(0, 3) : 0, 0, 0);
            iter++;
         end
         check_quiet("round_quiet");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
